// File: rtl/mux_scan.sv
// Registered N-channel, W-bit multiplexer. In DIRECT mode the select input picks the lane.
// In SCAN mode the block walks the lanes round-robin, staying DWELL cycles on each lane.
module mux_scan #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 1,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          out,
    output logic [SELW-1:0]           ch,
    output logic                      valid,
    output logic                      wrap
);

    localparam int              DWW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW:0]   SEL_LIM = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);
    localparam logic [DWW-1:0]  LAST_DW = DWW'(DWELL - 1);

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] out_reg,   out_next;
    logic [SELW-1:0]  ch_reg,    ch_next;
    logic             valid_reg, valid_next;
    logic             wrap_reg,  wrap_next;
    logic [SELW-1:0]  ptr_reg,   ptr_next;
    logic [DWW-1:0]   dwell_reg, dwell_next;

    logic [WIDTH-1:0] lane [CHANNELS];
    logic             sel_ok;
    logic [SELW-1:0]  scan_ptr;
    logic [DWW-1:0]   scan_dwell;
    logic             last_dwell;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            assign lane[gi] = din[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Only meaningful when CHANNELS is not a power of two.
    assign sel_ok = ({1'b0, sel} < SEL_LIM);

    // Entering scan this edge: start from sel (or 0 if illegal) with a fresh dwell count,
    // so the entry edge is already the first sample of the new lane.
    assign scan_ptr   = (state_reg == ST_DIRECT) ? (sel_ok ? sel : '0) : ptr_reg;
    assign scan_dwell = (state_reg == ST_DIRECT) ? '0 : dwell_reg;
    assign last_dwell = (scan_dwell == LAST_DW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_DIRECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (en) begin
            state_next = mode ? ST_SCAN : ST_DIRECT;
        end
    end

    always_comb begin
        out_next   = out_reg;
        ch_next    = ch_reg;
        valid_next = 1'b0;
        wrap_next  = 1'b0;
        ptr_next   = ptr_reg;
        dwell_next = dwell_reg;
        if (en) begin
            if (state_next == ST_SCAN) begin
                out_next   = lane[scan_ptr];
                ch_next    = scan_ptr;
                valid_next = 1'b1;
                wrap_next  = last_dwell && (scan_ptr == LAST_CH);
                if (last_dwell) begin
                    dwell_next = '0;
                    ptr_next   = (scan_ptr == LAST_CH) ? '0 : scan_ptr + SELW'(1);
                end else begin
                    dwell_next = scan_dwell + DWW'(1);
                    ptr_next   = scan_ptr;
                end
            end else begin
                ch_next = sel;
                if (sel_ok) begin
                    out_next   = lane[sel];
                    valid_next = 1'b1;
                end else begin
                    out_next   = '0;
                    valid_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg   <= '0;
            ch_reg    <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            ptr_reg   <= '0;
            dwell_reg <= '0;
        end else begin
            out_reg   <= out_next;
            ch_reg    <= ch_next;
            valid_reg <= valid_next;
            wrap_reg  <= wrap_next;
            ptr_reg   <= ptr_next;
            dwell_reg <= dwell_next;
        end
    end

    assign out   = out_reg;
    assign ch    = ch_reg;
    assign valid = valid_reg;
    assign wrap  = wrap_reg;

endmodule
